// File: rtl/stream_demux4.sv
// stream_demux4 -- 1-to-4 packet-aware stream demultiplexer.
//
// Routes one valid/ready input stream to one of four output channels. The
// destination is taken from in_sel on the first beat of a packet and held
// (LOCK state) until the in_last beat is accepted. Each channel owns a
// 1-deep register slice, so all outputs are registered and every channel
// drains on its own.
//
// Handshake: a beat moves across an interface in any cycle where valid and
// ready are both 1. Valid never waits on ready. While valid is 1 and ready
// is 0, the producer holds the beat stable.
//
// Optional feature: define DEMUX_CNT_EN to add per-channel accepted-beat
// counters (ports cnt_clr and beat_cnt).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data, in_sel       input payload, destination channel (first beat only)
//   in_last               final beat of a packet
//   out_valid[3:0]        per-channel valid
//   out_ready[3:0]        per-channel consumer ready
//   out_data              channel i on bits [i*DATA_W +: DATA_W]
//   out_last[3:0]         per-channel last flag
//   busy                  1 while mid-packet (LOCK state); this is the FSM state
//   cur_ch                channel currently routed
//   cnt_clr, beat_cnt     (DEMUX_CNT_EN only) counter clear, 4 x 16-bit counts
module stream_demux4 #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_last,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            out_last,
  output logic                  busy,
  output logic [1:0]            cur_ch
`ifdef DEMUX_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [4*16-1:0]       beat_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      lock_ch_q, lock_ch_d;
  logic [1:0]      ch;
  logic [3:0]      ch_oh;
  logic            accept;

  logic [3:0]        valid_q;
  logic [DATA_W-1:0] data_q [4];
  logic [3:0]        last_q;

  // Channel is free-running from in_sel while idle, frozen while locked.
  assign ch     = (state_q == LOCK) ? lock_ch_q : in_sel;
  assign ch_oh  = 4'b0001 << ch;
  assign cur_ch = ch;
  assign busy   = (state_q == LOCK);

  // A full slice that is draining this cycle can take a new beat, so the
  // stream runs at full rate with no bubble.
  assign in_ready = ~valid_q[ch] | out_ready[ch];
  assign accept   = in_valid & in_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d   = LOCK;
          lock_ch_d = in_sel;
        end
      end
      LOCK: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-channel register slices. A load wins over a drain in the same cycle;
  // data/last are left alone on a drain and only change on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      last_q  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && ch_oh[i]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= in_data;
          last_q[i]  <= in_last;
        end else if (out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_data[g*DATA_W +: DATA_W] = data_q[g];
  end

`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_q [4];

  // Clear has priority over a same-cycle increment; counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr) begin
          cnt_q[i] <= 16'd0;
        end else if (accept && ch_oh[i]) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign beat_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule
